// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the CORDIC request arbiter: the requester tag
// that travels beside the core, and the fixed stage-0 angle seed.
package cordic_arb_pkg;

   // Tag id storage width; covers up to 16 requesters, narrower ids are zero-extended.
   localparam int TAG_ID_W   = 4;
   localparam int ANGLE_ZERO = 0;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
      logic                mode;
   } tag_t;

   function automatic int next_idx(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cordic_arb_rr.sv
// Round-robin grant: combinational one-hot pick of the first request at or
// after the pointer, and a pointer that moves past the winner on each grant.
module cordic_rr_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_grant_valid,
   output logic [ID_W-1:0]    o_grant_idx,
   output logic [ID_W-1:0]    o_ptr
);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_cand;

   always_comb begin : p_scan
      int v_idx;
      o_grant       = '0;
      o_grant_valid = 1'b0;
      o_grant_idx   = '0;
      w_cand        = '0;
      v_idx         = 0;
      if (i_enable) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            w_cand = ID_W'(v_idx);
            if (!o_grant_valid && i_req[w_cand]) begin
               o_grant_valid   = 1'b1;
               o_grant_idx     = w_cand;
               o_grant[w_cand] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (o_grant_valid) begin
         r_ptr <= ID_W'(next_idx(int'(o_grant_idx), NUM_REQ));
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined CORDIC core among NUM_REQ requesters: round-robin issue,
// requester tags carried in a shadow pipe, one valid/ready response port.
module cordic_arbiter
   import cordic_arb_pkg::*;
#(
   parameter  int BIT_WIDTH = 16,
   parameter  int NUM_REQ   = 4,
   parameter  int LATENCY   = 16,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   output logic [NUM_REQ-1:0]           o_req_ready,
   input  logic [NUM_REQ*BIT_WIDTH-1:0] i_req_angle,
   input  logic [NUM_REQ*BIT_WIDTH-1:0] i_req_x,
   input  logic [NUM_REQ*BIT_WIDTH-1:0] i_req_y,
   input  logic [NUM_REQ-1:0]           i_req_mode,
   output logic                         o_core_start,
   output logic [BIT_WIDTH-1:0]         o_core_target_angle,
   output logic [BIT_WIDTH-1:0]         o_core_x,
   output logic [BIT_WIDTH-1:0]         o_core_y,
   output logic [BIT_WIDTH:0]           o_core_current_angle,
   output logic                         o_core_mode,
   output logic                         o_core_done,
   input  logic [BIT_WIDTH-1:0]         i_core_res_x,
   input  logic [BIT_WIDTH-1:0]         i_core_res_y,
   input  logic [BIT_WIDTH:0]           i_core_res_angle,
   input  logic                         i_core_res_done,
   output logic                         o_resp_valid,
   input  logic                         i_resp_ready,
   output logic [ID_W-1:0]              o_resp_id,
   output logic [BIT_WIDTH-1:0]         o_resp_x,
   output logic [BIT_WIDTH-1:0]         o_resp_y,
   output logic [BIT_WIDTH:0]           o_resp_angle,
   output logic                         o_resp_mode,
   output logic                         o_busy,
   output logic                         o_tag_error,
   output logic [ID_W-1:0]              o_dbg_rr_ptr
);

   localparam int CNT_W = $clog2(LATENCY + 1);

   logic [BIT_WIDTH-1:0] w_angle_arr [NUM_REQ];
   logic [BIT_WIDTH-1:0] w_x_arr     [NUM_REQ];
   logic [BIT_WIDTH-1:0] w_y_arr     [NUM_REQ];

   logic            w_stall;
   logic            w_advance;
   logic            w_accept;
   logic            w_grant_valid;
   logic [ID_W-1:0] w_grant_idx;
   tag_t            w_tag_in;
   tag_t            r_tag [LATENCY];
   logic [CNT_W-1:0] r_inflight;
   logic            r_tag_error;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_angle_arr[gi] = i_req_angle[gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_x_arr[gi]     = i_req_x[gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_y_arr[gi]     = i_req_y[gi*BIT_WIDTH +: BIT_WIDTH];
   end

   // A held result freezes the core, the tag pipe and the arbiter together.
   assign w_stall   = r_tag[LATENCY-1].valid & ~i_resp_ready;
   assign w_advance = ~w_stall;
   assign w_accept  = r_tag[LATENCY-1].valid & i_resp_ready;

   cordic_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_enable      (w_advance),
      .i_req         (i_req_valid),
      .o_grant       (o_req_ready),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx),
      .o_ptr         (o_dbg_rr_ptr)
   );

   always_comb begin
      o_core_target_angle = '0;
      o_core_x            = '0;
      o_core_y            = '0;
      o_core_mode         = 1'b0;
      w_tag_in            = '0;
      if (w_grant_valid) begin
         o_core_target_angle = w_angle_arr[w_grant_idx];
         o_core_x            = w_x_arr[w_grant_idx];
         o_core_y            = w_y_arr[w_grant_idx];
         o_core_mode         = i_req_mode[w_grant_idx];
         w_tag_in.valid      = 1'b1;
         w_tag_in.id         = TAG_ID_W'(w_grant_idx);
         w_tag_in.mode       = i_req_mode[w_grant_idx];
      end
   end

   assign o_core_start         = w_advance;
   assign o_core_done          = w_grant_valid;
   assign o_core_current_angle = (BIT_WIDTH+1)'(ANGLE_ZERO);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
      end else if (w_advance) begin
         r_tag[0] <= w_tag_in;
         for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_inflight <= '0;
      end else begin
         case ({w_grant_valid, w_accept})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Sticky: any disagreement between our tag and the core's valid bit is fatal to ordering.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tag_error <= 1'b0;
      end else if (r_tag[LATENCY-1].valid != i_core_res_done) begin
         r_tag_error <= 1'b1;
      end
   end

   assign o_resp_valid = r_tag[LATENCY-1].valid;
   assign o_resp_id    = r_tag[LATENCY-1].id[ID_W-1:0];
   assign o_resp_mode  = r_tag[LATENCY-1].mode;
   assign o_resp_x     = i_core_res_x;
   assign o_resp_y     = i_core_res_y;
   assign o_resp_angle = i_core_res_angle;
   assign o_busy       = (r_inflight != '0);
   assign o_tag_error  = r_tag_error;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a behavioural delay-line core, a round-robin
// reference model and an expected-result queue checked every cycle.
module tb_cordic_arbiter;

   localparam int BW  = 16;
   localparam int NR  = 4;
   localparam int LAT = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NR-1:0]    req_valid, req_ready, req_mode;
   logic [NR*BW-1:0] req_angle, req_x, req_y;
   logic             core_start, core_mode, core_done;
   logic [BW-1:0]    core_target_angle, core_x, core_y;
   logic [BW:0]      core_current_angle;
   logic [BW-1:0]    core_res_x, core_res_y;
   logic [BW:0]      core_res_angle;
   logic             core_res_done;
   logic             resp_valid, resp_ready, resp_mode, busy, tag_error;
   logic [1:0]       resp_id, dbg_rr_ptr;
   logic [BW-1:0]    resp_x, resp_y;
   logic [BW:0]      resp_angle;

   always #5 clk = ~clk;

   cordic_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_angle(req_angle), .i_req_x(req_x), .i_req_y(req_y), .i_req_mode(req_mode),
      .o_core_start(core_start), .o_core_target_angle(core_target_angle),
      .o_core_x(core_x), .o_core_y(core_y), .o_core_current_angle(core_current_angle),
      .o_core_mode(core_mode), .o_core_done(core_done),
      .i_core_res_x(core_res_x), .i_core_res_y(core_res_y),
      .i_core_res_angle(core_res_angle), .i_core_res_done(core_res_done),
      .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_id(resp_id),
      .o_resp_x(resp_x), .o_resp_y(resp_y), .o_resp_angle(resp_angle),
      .o_resp_mode(resp_mode), .o_busy(busy), .o_tag_error(tag_error),
      .o_dbg_rr_ptr(dbg_rr_ptr)
   );

   // Behavioural core: LAT-deep delay line advancing on core_start, reset with the arbiter.
   logic [BW-1:0] cm_x [LAT];
   logic [BW-1:0] cm_y [LAT];
   logic [BW-1:0] cm_a [LAT];
   logic          cm_d [LAT];
   logic          force_done = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            cm_x[i] <= '0; cm_y[i] <= '0; cm_a[i] <= '0; cm_d[i] <= 1'b0;
         end
      end else if (core_start) begin
         cm_x[0] <= core_x; cm_y[0] <= core_y; cm_a[0] <= core_target_angle; cm_d[0] <= core_done;
         for (int i = 1; i < LAT; i++) begin
            cm_x[i] <= cm_x[i-1]; cm_y[i] <= cm_y[i-1]; cm_a[i] <= cm_a[i-1]; cm_d[i] <= cm_d[i-1];
         end
      end
   end

   assign core_res_x     = cm_x[LAT-1];
   assign core_res_y     = cm_y[LAT-1];
   assign core_res_angle = {cm_a[LAT-1][BW-1], cm_a[LAT-1]};
   assign core_res_done  = cm_d[LAT-1] | force_done;

   // Requesters: rq_cnt = outstanding requests, -1 = always requesting.
   logic [BW-1:0] rq_angle [NR];
   logic [BW-1:0] rq_x     [NR];
   logic [BW-1:0] rq_y     [NR];
   logic          rq_mode  [NR];
   int            rq_cnt   [NR];

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_valid[i]            = (rq_cnt[i] != 0);
         req_mode[i]             = rq_mode[i];
         req_angle[i*BW +: BW]   = rq_angle[i];
         req_x[i*BW +: BW]       = rq_x[i];
         req_y[i*BW +: BW]       = rq_y[i];
      end
   end

   typedef struct packed {
      logic [1:0]  id;
      logic        mode;
      logic [15:0] x;
      logic [15:0] y;
      logic [16:0] ang;
      logic [4:0]  rem;
   } exp_t;

   exp_t exp_q[$];
   int   grant_log[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_ptr    = 0;
   logic m_tag_err = 1'b0;
   int   cyc = 0;
   int   last_grant_cyc = 0;
   int   last_resp_cyc  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh(input int g);
      rq_angle[g] = 16'($urandom_range(0, 65535));
      rq_x[g]     = 16'($urandom_range(0, 65535));
      rq_y[g]     = 16'($urandom_range(0, 65535));
      rq_mode[g]  = 1'($urandom_range(0, 1));
   endtask

   // One clock: check at negedge, update model at posedge, change stimulus #1 later.
   task automatic tick();
      logic       exp_rv, stall, gv;
      int         g;
      logic [3:0] exp_rdy;
      exp_t       e;
      @(negedge clk);
      exp_rv = (exp_q.size() > 0) && (exp_q[0].rem == 0);
      stall  = exp_rv && !resp_ready;
      gv = 1'b0;
      g  = 0;
      if (!stall) begin
         for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (!gv && rq_cnt[idx] != 0) begin gv = 1'b1; g = idx; end
         end
      end
      exp_rdy = gv ? 4'(1 << g) : 4'b0;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("core_done", 32'(core_done), 32'(gv));
      check("core_start", 32'(core_start), 32'(!stall));
      check("core_cur_angle", 32'(core_current_angle), 32'd0);
      check("rr_ptr", 32'(dbg_rr_ptr), 32'(m_ptr));
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("tag_error", 32'(tag_error), 32'(m_tag_err));
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (gv) begin
         check("core_x", 32'(core_x), 32'(rq_x[g]));
         check("core_y", 32'(core_y), 32'(rq_y[g]));
         check("core_angle", 32'(core_target_angle), 32'(rq_angle[g]));
         check("core_mode", 32'(core_mode), 32'(rq_mode[g]));
      end else begin
         check("core_bubble", {core_x, core_y}, 32'd0);
         check("core_bubble_a", 32'({core_target_angle, core_mode}), 32'd0);
      end
      if (exp_rv) begin
         check("resp_id", 32'(resp_id), 32'(exp_q[0].id));
         check("resp_mode", 32'(resp_mode), 32'(exp_q[0].mode));
         check("resp_x", 32'(resp_x), 32'(exp_q[0].x));
         check("resp_y", 32'(resp_y), 32'(exp_q[0].y));
         check("resp_angle", 32'(resp_angle), 32'(exp_q[0].ang));
      end
      @(posedge clk);
      cyc++;
      if (exp_rv && resp_ready) begin
         void'(exp_q.pop_front());
         last_resp_cyc = cyc;
      end
      if (!stall) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            if (e.rem != 0) e.rem = e.rem - 5'd1;
            exp_q[i] = e;
         end
      end
      if (gv) begin
         e.id   = 2'(g);
         e.mode = rq_mode[g];
         e.x    = rq_x[g];
         e.y    = rq_y[g];
         e.ang  = {rq_angle[g][BW-1], rq_angle[g]};
         e.rem  = 5'(LAT - 1);
         exp_q.push_back(e);
         grant_log.push_back(g);
         m_ptr = (g + 1) % NR;
         last_grant_cyc = cyc;
      end
      if (force_done && !exp_rv) m_tag_err = 1'b1;
      #1;
      if (gv) begin
         if (rq_cnt[g] > 0) rq_cnt[g] = rq_cnt[g] - 1;
         refresh(g);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NR; i++) rq_cnt[i] = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      grant_log.delete();
      m_ptr = 0;
      m_tag_err = 1'b0;
   endtask

   initial begin
      resp_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin rq_cnt[i] = 0; refresh(i); end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset values.
      @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_resp_mode", 32'(resp_mode), 32'd0);
      check("rst_core_mode", 32'(core_mode), 32'd0);
      check("rst_core_start", 32'(core_start), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tag_error", 32'(tag_error), 32'd0);
      @(posedge clk);
      #1;

      // Single request from requester 2.
      rq_angle[2] = 16'h4000; rq_x[2] = 16'h4DBA; rq_y[2] = 16'h0000; rq_mode[2] = 1'b0;
      rq_cnt[2] = 1;
      repeat (20) tick();
      check("single_latency", 32'(last_resp_cyc - last_grant_cyc), 32'(LAT));
      check("single_grant", 32'(grant_log.size() == 1 ? grant_log[0] : -1), 32'd2);

      // All four requesting continuously, then a 5-cycle response stall.
      do_reset();
      for (int i = 0; i < NR; i++) rq_cnt[i] = -1;
      repeat (20) tick();
      for (int i = 0; i < 8; i++) check("rr_order", 32'(grant_log[i]), 32'(i % NR));
      resp_ready = 1'b0;
      repeat (5) tick();
      resp_ready = 1'b1;
      repeat (10) tick();
      for (int i = 0; i < NR; i++) rq_cnt[i] = 0;
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
      check("stream_drained", 32'(exp_q.size()), 32'd0);

      // Requests on 1 and 3 with the pointer at 2.
      do_reset();
      rq_cnt[1] = 1;
      tick();
      rq_cnt[1] = 1;
      rq_cnt[3] = 1;
      repeat (3) tick();
      check("wrap_grants", 32'(grant_log.size()), 32'd3);
      check("wrap_first", 32'(grant_log[1]), 32'd3);
      check("wrap_second", 32'(grant_log[2]), 32'd1);
      repeat (20) tick();
      check("wrap_drained", 32'(exp_q.size()), 32'd0);

      // Reset with 8 operations in flight.
      for (int i = 0; i < NR; i++) rq_cnt[i] = -1;
      repeat (8) tick();
      check("inflight_8", 32'(exp_q.size()), 32'd8);
      do_reset();
      @(negedge clk);
      check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ptr", 32'(dbg_rr_ptr), 32'd0);
      check("mid_rst_tag_error", 32'(tag_error), 32'd0);
      @(posedge clk);
      #1;
      repeat (20) tick();

      // Core valid without a matching tag.
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      repeat (5) tick();
      check("tag_error_held", 32'(tag_error), 32'd1);
      do_reset();
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
